// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin share of one UART TX engine among NUM_REQ
// requesters, with a post-frame idle gap and a tx_done watchdog.
//
// Ports:
//   clk, reset       : clock, async active-high reset
//   req, req_data    : per-requester level request and byte (8 bits each)
//   baud_set_in      : baud code captured at grant
//   grant, done      : one-hot grant for SEND, one-cycle completion pulse
//   timeout_err      : one-cycle pulse on watchdog abort
//   busy             : high in SEND and GAP
//   tx_data, tx_send_en, tx_baud_set, tx_done : TX engine interface

module uart_tx_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int GAP_CYCLES     = 4,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [3:0]           baud_set_in,
  output logic [NUM_REQ-1:0]   grant,
  output logic [NUM_REQ-1:0]   done,
  output logic                 timeout_err,
  output logic                 busy,
  output logic [7:0]           tx_data,
  output logic                 tx_send_en,
  output logic [3:0]           tx_baud_set,
  input  logic                 tx_done
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int WW = $clog2(TIMEOUT_CYCLES);
  localparam int GW = $clog2(GAP_CYCLES);

  localparam logic [WW-1:0] WD_TC  = WW'(TIMEOUT_CYCLES - 1);
  localparam logic [GW-1:0] GAP_TC = GW'(GAP_CYCLES - 1);
  localparam logic [IW-1:0] LAST0  = IW'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    GAP
  } state_t;

  state_t state_q, state_d;

  logic [IW-1:0]      last_q, last_d;
  logic [IW-1:0]      pick;
  logic [7:0]         pick_data;
  logic [WW-1:0]      wd_q, wd_d;
  logic [GW-1:0]      gap_q, gap_d;
  logic [NUM_REQ-1:0] grant_d, done_d;
  logic               terr_d, busy_d, en_d;
  logic [7:0]         data_d;
  logic [3:0]         baud_d;

  function automatic logic [IW-1:0] rr_idx(
    input logic [IW-1:0] base,
    input int            k
  );
    int j;
    j = int'(base) + k;
    if (j >= NUM_REQ) j = j - NUM_REQ;
    return IW'(j);
  endfunction

  // Scan farthest-first so the nearest set bit after last_q wins.
  always_comb begin
    pick      = last_q;
    pick_data = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      if (req[rr_idx(last_q, i)]) pick = rr_idx(last_q, i);
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick == IW'(i)) pick_data = req_data[8*i +: 8];
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    wd_d    = wd_q;
    gap_d   = gap_q;
    grant_d = grant;
    done_d  = '0;
    terr_d  = 1'b0;
    en_d    = tx_send_en;
    data_d  = tx_data;
    baud_d  = tx_baud_set;
    unique case (state_q)
      IDLE: begin
        if (|req) begin
          state_d = SEND;
          grant_d = NUM_REQ'(1) << pick;
          en_d    = 1'b1;
          data_d  = pick_data;
          baud_d  = baud_set_in;
          last_d  = pick;
          wd_d    = '0;
        end
      end
      SEND: begin
        if (tx_done) begin
          state_d = GAP;
          grant_d = '0;
          en_d    = 1'b0;
          done_d  = grant;
          gap_d   = '0;
        end else if (wd_q == WD_TC) begin
          state_d = GAP;
          grant_d = '0;
          en_d    = 1'b0;
          terr_d  = 1'b1;
          gap_d   = '0;
        end else if (wd_q != '1) begin
          wd_d = wd_q + WW'(1);
        end
      end
      GAP: begin
        if (gap_q == GAP_TC) state_d = IDLE;
        else gap_d = gap_q + GW'(1);
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      last_q      <= LAST0;
      wd_q        <= '0;
      gap_q       <= '0;
      grant       <= '0;
      done        <= '0;
      timeout_err <= 1'b0;
      busy        <= 1'b0;
      tx_data     <= 8'h00;
      tx_send_en  <= 1'b0;
      tx_baud_set <= 4'd0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      wd_q        <= wd_d;
      gap_q       <= gap_d;
      grant       <= grant_d;
      done        <= done_d;
      timeout_err <= terr_d;
      busy        <= busy_d;
      tx_data     <= data_d;
      tx_send_en  <= en_d;
      tx_baud_set <= baud_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: scenario tasks against a round-robin reference model.
// Inputs change and outputs are sampled 1 ns after each rising edge.

module tb_uart_tx_arbiter;

  localparam int N   = 4;
  localparam int GAP = 4;
  localparam int TO  = 50;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [N-1:0]   req = '0;
  logic [8*N-1:0] req_data = '0;
  logic [3:0]     baud_set_in = '0;
  logic           tx_done = 1'b0;
  logic [N-1:0]   grant, done;
  logic           timeout_err, busy, tx_send_en;
  logic [7:0]     tx_data;
  logic [3:0]     tx_baud_set;

  int checks = 0;
  int fails  = 0;
  int last_g = N - 1;

  uart_tx_arbiter #(
    .NUM_REQ(N),
    .GAP_CYCLES(GAP),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk),
    .reset(reset),
    .req(req),
    .req_data(req_data),
    .baud_set_in(baud_set_in),
    .grant(grant),
    .done(done),
    .timeout_err(timeout_err),
    .busy(busy),
    .tx_data(tx_data),
    .tx_send_en(tx_send_en),
    .tx_baud_set(tx_baud_set),
    .tx_done(tx_done)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference: first set request after the last winner, with wrap.
  function automatic int rr_pick(input int last, input logic [N-1:0] r);
    for (int k = 1; k <= N; k++) begin
      if (r[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] oh(input int i);
    logic [N-1:0] v;
    v = '0;
    if (i >= 0) v[i] = 1'b1;
    return v;
  endfunction

  function automatic logic [N-1:0] rand_req();
    return N'($urandom_range(1, (1 << N) - 1));
  endfunction

  task automatic test_reset;
    reset = 1'b1;
    tick;
    tick;
    checks++;
    if ({grant, done, timeout_err, busy, tx_send_en} !== '0) begin
      fails++;
      $display("FAIL reset_ctrl grant=%b done=%b terr=%b busy=%b en=%b",
               grant, done, timeout_err, busy, tx_send_en);
    end
    checks++;
    if (tx_data !== 8'h00 || tx_baud_set !== 4'd0) begin
      fails++;
      $display("FAIL reset_data got %h/%h want 00/0", tx_data, tx_baud_set);
    end
    reset = 1'b0;
    last_g = N - 1;
  endtask

  task automatic test_single;
    int hold;
    req_data[23:16] = 8'hA5;
    baud_set_in = 4'd4;
    req = 4'b0100;
    tick;
    checks++;
    if (grant !== 4'b0100 || tx_send_en !== 1'b1 || busy !== 1'b1) begin
      fails++;
      $display("FAIL single_grant grant=%b en=%b busy=%b want 0100/1/1",
               grant, tx_send_en, busy);
    end
    checks++;
    if (tx_data !== 8'hA5 || tx_baud_set !== 4'd4) begin
      fails++;
      $display("FAIL single_data got %h/%0d want a5/4", tx_data, tx_baud_set);
    end
    last_g = 2;
    req = '0;
    hold = $urandom_range(2, 8);
    repeat (hold) begin
      tick;
      checks++;
      if (grant !== 4'b0100 || tx_send_en !== 1'b1 || done !== '0) begin
        fails++;
        $display("FAIL single_hold grant=%b en=%b done=%b", grant,
                 tx_send_en, done);
      end
    end
    tx_done = 1'b1;
    tick;
    tx_done = 1'b0;
    checks++;
    if (done !== 4'b0100 || grant !== '0 || tx_send_en !== 1'b0 ||
        timeout_err !== 1'b0 || busy !== 1'b1) begin
      fails++;
      $display("FAIL single_done done=%b grant=%b en=%b terr=%b busy=%b",
               done, grant, tx_send_en, timeout_err, busy);
    end
    for (int i = 1; i < GAP; i++) begin
      tick;
      checks++;
      if (busy !== 1'b1 || tx_send_en !== 1'b0 || done !== '0) begin
        fails++;
        $display("FAIL single_gap%0d busy=%b en=%b done=%b", i, busy,
                 tx_send_en, done);
      end
    end
    tick;
    checks++;
    if (busy !== 1'b0 || tx_send_en !== 1'b0) begin
      fails++;
      $display("FAIL single_gap_end busy=%b en=%b want 0/0", busy, tx_send_en);
    end
  endtask

  task automatic test_round_robin;
    int n, exp, lat, hold;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    last_g = N - 1;
    req_data = {$urandom};
    baud_set_in = 4'($urandom);
    req = '1;
    for (int f = 0; f < 5; f++) begin
      n = 0;
      while (grant === '0 && n < 20) begin
        tick;
        n++;
      end
      exp = rr_pick(last_g, req);
      lat = (f == 0) ? 1 : GAP + 1;
      checks++;
      if (grant !== oh(exp) || n != lat) begin
        fails++;
        $display("FAIL rr_grant%0d grant=%b lat=%0d want %b lat=%0d", f,
                 grant, n, oh(exp), lat);
      end
      checks++;
      if (tx_data !== req_data[8*exp +: 8] || tx_baud_set !== baud_set_in) begin
        fails++;
        $display("FAIL rr_data%0d got %h/%0d want %h/%0d", f, tx_data,
                 tx_baud_set, req_data[8*exp +: 8], baud_set_in);
      end
      last_g = exp;
      hold = $urandom_range(0, 5);
      repeat (hold) tick;
      tx_done = 1'b1;
      tick;
      tx_done = 1'b0;
      checks++;
      if (done !== oh(exp)) begin
        fails++;
        $display("FAIL rr_done%0d got %b want %b", f, done, oh(exp));
      end
    end
    req = '0;
    repeat (GAP + 1) tick;
  endtask

  task automatic test_freeze;
    int n;
    req_data[7:0] = 8'h3C;
    baud_set_in = 4'd0;
    req = 4'b0001;
    n = 0;
    while (grant === '0 && n < 20) begin
      tick;
      n++;
    end
    checks++;
    if (grant !== 4'b0001 || tx_data !== 8'h3C || tx_baud_set !== 4'd0) begin
      fails++;
      $display("FAIL freeze_grant grant=%b data=%h baud=%0d", grant,
               tx_data, tx_baud_set);
    end
    last_g = 0;
    req_data[7:0] = 8'hFF;
    baud_set_in = 4'd2;
    repeat (5) begin
      tick;
      checks++;
      if (tx_data !== 8'h3C || tx_baud_set !== 4'd0) begin
        fails++;
        $display("FAIL freeze_hold got %h/%0d want 3c/0", tx_data,
                 tx_baud_set);
      end
    end
    tx_done = 1'b1;
    tick;
    tx_done = 1'b0;
    checks++;
    if (done !== 4'b0001) begin
      fails++;
      $display("FAIL freeze_done got %b want 0001", done);
    end
    req = '0;
    repeat (GAP + 1) tick;
  endtask

  task automatic test_timeout;
    int n, r, r2, bad;
    r = $urandom_range(0, N - 1);
    req = oh(r);
    n = 0;
    while (grant === '0 && n < 20) begin
      tick;
      n++;
    end
    checks++;
    if (grant !== oh(r)) begin
      fails++;
      $display("FAIL to_grant got %b want %b", grant, oh(r));
    end
    last_g = r;
    req = '0;
    bad = 0;
    for (int k = 1; k < TO; k++) begin
      tick;
      if (timeout_err !== 1'b0 || done !== '0 || grant !== oh(r)) bad++;
    end
    checks++;
    if (bad != 0) begin
      fails++;
      $display("FAIL to_early %0d bad cycles want 0", bad);
    end
    r2 = (r + 1 + $urandom_range(0, N - 2)) % N;
    req = oh(r2);
    tick;
    checks++;
    if (timeout_err !== 1'b1 || done !== '0 || grant !== '0 ||
        tx_send_en !== 1'b0) begin
      fails++;
      $display("FAIL to_pulse terr=%b done=%b grant=%b en=%b", timeout_err,
               done, grant, tx_send_en);
    end
    tick;
    checks++;
    if (timeout_err !== 1'b0) begin
      fails++;
      $display("FAIL to_one_cycle terr=%b want 0", timeout_err);
    end
    n = 0;
    while (grant === '0 && n < 20) begin
      tick;
      n++;
    end
    checks++;
    if (grant !== oh(rr_pick(last_g, req)) || n != GAP) begin
      fails++;
      $display("FAIL to_next grant=%b n=%0d want %b n=%0d", grant, n,
               oh(rr_pick(last_g, req)), GAP);
    end
    last_g = r2;
    tx_done = 1'b1;
    tick;
    tx_done = 1'b0;
    checks++;
    if (done !== oh(r2)) begin
      fails++;
      $display("FAIL to_next_done got %b want %b", done, oh(r2));
    end
    req = '0;
    repeat (GAP + 1) tick;
  endtask

  task automatic test_collision;
    int n, r;
    r = $urandom_range(0, N - 1);
    req = oh(r);
    n = 0;
    while (grant === '0 && n < 20) begin
      tick;
      n++;
    end
    last_g = r;
    req = '0;
    repeat (TO - 1) tick;
    tx_done = 1'b1;
    tick;
    tx_done = 1'b0;
    checks++;
    if (done !== oh(r) || timeout_err !== 1'b0) begin
      fails++;
      $display("FAIL collision done=%b terr=%b want %b/0", done,
               timeout_err, oh(r));
    end
    tick;
    checks++;
    if (timeout_err !== 1'b0 || done !== '0) begin
      fails++;
      $display("FAIL collision_after terr=%b done=%b want 0/0",
               timeout_err, done);
    end
    tx_done = 1'b1;
    repeat (GAP + 2) tick;
    checks++;
    if (busy !== 1'b0 || done !== '0 || grant !== '0) begin
      fails++;
      $display("FAIL stray_done busy=%b done=%b grant=%b want 0", busy,
               done, grant);
    end
    tx_done = 1'b0;
  endtask

  task automatic test_reset_mid;
    int n;
    req_data[15:8] = 8'h5A;
    baud_set_in = 4'h9;
    req = 4'b0010;
    n = 0;
    while (grant === '0 && n < 20) begin
      tick;
      n++;
    end
    checks++;
    if (grant !== 4'b0010) begin
      fails++;
      $display("FAIL rst_mid_grant got %b want 0010", grant);
    end
    repeat (3) tick;
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if ({grant, done, timeout_err, busy, tx_send_en} !== '0 ||
        tx_data !== 8'h00 || tx_baud_set !== 4'd0) begin
      fails++;
      $display("FAIL rst_mid_async grant=%b en=%b busy=%b data=%h baud=%0d",
               grant, tx_send_en, busy, tx_data, tx_baud_set);
    end
    tick;
    reset = 1'b0;
    last_g = N - 1;
    n = 0;
    while (grant === '0 && n < 20) begin
      tick;
      n++;
    end
    checks++;
    if (grant !== 4'b0010 || n != 1 || tx_data !== 8'h5A) begin
      fails++;
      $display("FAIL rst_mid_regrant grant=%b n=%0d data=%h want 0010/1/5a",
               grant, n, tx_data);
    end
    last_g = 1;
    tx_done = 1'b1;
    tick;
    tx_done = 1'b0;
    req = '0;
    repeat (GAP + 1) tick;
  endtask

  task automatic test_back_to_back;
    int n, exp, hold;
    logic [7:0] eb;
    logic [3:0] ebaud;
    req = rand_req();
    for (int f = 0; f < 30; f++) begin
      req_data = {$urandom};
      baud_set_in = 4'($urandom);
      n = 0;
      while (grant === '0 && n < 20) begin
        tick;
        n++;
      end
      exp = rr_pick(last_g, req);
      eb = req_data[8*exp +: 8];
      ebaud = baud_set_in;
      checks++;
      if (grant !== oh(exp) || tx_data !== eb || tx_baud_set !== ebaud) begin
        fails++;
        $display("FAIL b2b_grant%0d grant=%b data=%h baud=%0d want %b/%h/%0d",
                 f, grant, tx_data, tx_baud_set, oh(exp), eb, ebaud);
      end
      last_g = exp;
      req = rand_req();
      req_data = {$urandom};
      baud_set_in = 4'($urandom);
      hold = $urandom_range(0, 6);
      repeat (hold) begin
        tick;
        checks++;
        if (grant !== oh(exp) || tx_data !== eb || tx_baud_set !== ebaud) begin
          fails++;
          $display("FAIL b2b_hold%0d grant=%b data=%h baud=%0d", f, grant,
                   tx_data, tx_baud_set);
        end
      end
      tx_done = 1'b1;
      tick;
      tx_done = 1'b0;
      checks++;
      if (done !== oh(exp) || timeout_err !== 1'b0) begin
        fails++;
        $display("FAIL b2b_done%0d done=%b terr=%b want %b/0", f, done,
                 timeout_err, oh(exp));
      end
    end
    req = '0;
    repeat (GAP + 1) tick;
  endtask

  initial begin
    test_reset;
    test_single;
    test_round_robin;
    test_freeze;
    test_timeout;
    test_collision;
    test_reset_mid;
    test_back_to_back;
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
